// File: rtl/qracc_sram_arbiter_if.sv
// SRAM-side request/response bundle shared by the arbiter and the SRAM.
//   master modport (arbiter): drives the request channel (valid, wr, addr,
//                             wr_data) and receives ready plus read-return.
//   slave modport  (SRAM)   : the mirror image.
// Parameters: AW = row address width, DW = word width.
interface qracc_sram_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          sram_rq_valid_o;
  logic          sram_rq_wr_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wr_data_o;
  logic          sram_rq_ready_i;
  logic          sram_rd_valid_i;
  logic [DW-1:0] sram_rd_data_i;

  modport master (
    output sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o,
    input  sram_rq_ready_i, sram_rd_valid_i, sram_rd_data_i
  );

  modport slave (
    input  sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o,
    output sram_rq_ready_i, sram_rd_valid_i, sram_rd_data_i
  );
endinterface

// File: rtl/qracc_sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported SRAM.
// Requester 0 is the host/config path, requester 1 the weight/feature loader.
// Ports:
//   clk, nrst                 : clock, asynchronous active-low reset
//   mK_rq_valid_i/wr_i/addr_i/wr_data_i : request from requester K
//   mK_rq_ready_o             : request accepted this cycle (IDLE only)
//   mK_rd_valid_o/rd_data_o   : one-cycle read-return pulse, data held after
//   sram_itf                  : SRAM request/response channel (master side)
//   conflict_count_o          : saturating count of IDLE cycles with both
//                               requesters valid
module qracc_sram_arbiter #(
  parameter int numRows = 128,
  parameter int numCols = 32,
  localparam int AW = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               m0_rq_valid_i,
  input  logic               m0_rq_wr_i,
  input  logic [AW-1:0]      m0_addr_i,
  input  logic [numCols-1:0] m0_wr_data_i,
  output logic               m0_rq_ready_o,
  output logic               m0_rd_valid_o,
  output logic [numCols-1:0] m0_rd_data_o,
  input  logic               m1_rq_valid_i,
  input  logic               m1_rq_wr_i,
  input  logic [AW-1:0]      m1_addr_i,
  input  logic [numCols-1:0] m1_wr_data_i,
  output logic               m1_rq_ready_o,
  output logic               m1_rd_valid_o,
  output logic [numCols-1:0] m1_rd_data_o,
  qracc_sram_arbiter_if.master sram_itf,
  output logic [15:0]        conflict_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t             state_r;
  logic               last_grant_r;
  logic               owner_r;
  logic               cap_wr_r;
  logic [AW-1:0]      cap_addr_r;
  logic [numCols-1:0] cap_data_r;
  logic               sram_valid_r;
  logic               m0_rd_valid_r;
  logic               m1_rd_valid_r;
  logic [numCols-1:0] m0_rd_data_r;
  logic [numCols-1:0] m1_rd_data_r;
  logic [15:0]        conflict_r;

  logic               both_s;
  logic               grant0_s;
  logic               grant1_s;

  // Grant decode: round-robin on a tie, favouring the requester not granted
  // last. Held low during reset so every output reads 0 while nrst=0.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    both_s   = m0_rq_valid_i & m1_rq_valid_i;
    if ((state_r == IDLE) && nrst) begin
      if (both_s) begin
        grant0_s = last_grant_r;
        grant1_s = ~last_grant_r;
      end else begin
        grant0_s = m0_rq_valid_i;
        grant1_s = m1_rq_valid_i;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Main FSM: capture on grant, present to SRAM until accepted, route read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= IDLE;
      last_grant_r  <= 1'b1;
      owner_r       <= 1'b0;
      cap_wr_r      <= 1'b0;
      cap_addr_r    <= '0;
      cap_data_r    <= '0;
      sram_valid_r  <= 1'b0;
      m0_rd_valid_r <= 1'b0;
      m1_rd_valid_r <= 1'b0;
      m0_rd_data_r  <= '0;
      m1_rd_data_r  <= '0;
      conflict_r    <= 16'd0;
    end else begin
      // Read-valid outputs are single-cycle pulses.
      m0_rd_valid_r <= 1'b0;
      m1_rd_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (both_s && (conflict_r != 16'hFFFF)) begin
            conflict_r <= conflict_r + 16'd1;
          end
          if (grant0_s || grant1_s) begin
            owner_r      <= grant1_s;
            last_grant_r <= grant1_s;
            cap_wr_r     <= grant1_s ? m1_rq_wr_i   : m0_rq_wr_i;
            cap_addr_r   <= grant1_s ? m1_addr_i    : m0_addr_i;
            cap_data_r   <= grant1_s ? m1_wr_data_i : m0_wr_data_i;
            sram_valid_r <= 1'b1;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          if (sram_itf.sram_rq_ready_i) begin
            sram_valid_r <= 1'b0;
            state_r      <= cap_wr_r ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (sram_itf.sram_rd_valid_i) begin
            if (owner_r) begin
              m1_rd_data_r  <= sram_itf.sram_rd_data_i;
              m1_rd_valid_r <= 1'b1;
            end else begin
              m0_rd_data_r  <= sram_itf.sram_rd_data_i;
              m0_rd_valid_r <= 1'b1;
            end
            state_r <= IDLE;
          end
        end
        default: begin
          sram_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign m0_rq_ready_o            = grant0_s;
  assign m1_rq_ready_o            = grant1_s;
  assign m0_rd_valid_o            = m0_rd_valid_r;
  assign m1_rd_valid_o            = m1_rd_valid_r;
  assign m0_rd_data_o             = m0_rd_data_r;
  assign m1_rd_data_o             = m1_rd_data_r;
  assign conflict_count_o         = conflict_r;
  assign sram_itf.sram_rq_valid_o = sram_valid_r;
  assign sram_itf.sram_rq_wr_o    = cap_wr_r;
  assign sram_itf.sram_addr_o     = cap_addr_r;
  assign sram_itf.sram_wr_data_o  = cap_data_r;

endmodule
